// File: rtl/vend_pkg.sv
// Shared state encoding and default widths for the vending controller slice.
// The optional inactivity timeout is enabled with VEND_TIMEOUT_EN.
package vend_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_PAY      = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_REFUND   = 2'd3
    } vend_state_e;

    localparam int DEF_N_PRODUCTS     = 8;
    localparam int DEF_PRICE_W        = 8;
    localparam int DEF_STOCK_W        = 4;
    localparam int DEF_INIT_STOCK     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/vend_slot_table.sv
// Price and stock storage per product slot with write, restock and decrement ports.
// Reads are combinational; an out-of-range index reads as price 0 / stock 0 (sold out).
module vend_slot_table #(
    parameter int N_PRODUCTS = vend_pkg::DEF_N_PRODUCTS,
    parameter int PRICE_W    = vend_pkg::DEF_PRICE_W,
    parameter int STOCK_W    = vend_pkg::DEF_STOCK_W,
    parameter int INIT_STOCK = vend_pkg::DEF_INIT_STOCK,
    localparam int ID_W      = $clog2(N_PRODUCTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_price_wr_en,
    input  logic [ID_W-1:0]    i_price_wr_id,
    input  logic [PRICE_W-1:0] i_price_wr_data,
    input  logic               i_restock_en,
    input  logic [ID_W-1:0]    i_restock_id,
    input  logic               i_dec_en,
    input  logic [ID_W-1:0]    i_dec_id,
    input  logic [ID_W-1:0]    i_rd_id,
    output logic [PRICE_W-1:0] o_rd_price,
    output logic [STOCK_W-1:0] o_rd_stock
);

    logic [PRICE_W-1:0] r_price [N_PRODUCTS];
    logic [STOCK_W-1:0] r_stock [N_PRODUCTS];

    // Restock has priority over a same-cycle decrement; stock saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                r_price[i] <= '0;
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                if (i_price_wr_en && (int'(i_price_wr_id) == i))
                    r_price[i] <= i_price_wr_data;
                if (i_restock_en && (int'(i_restock_id) == i))
                    r_stock[i] <= '1;
                else if (i_dec_en && (int'(i_dec_id) == i) && (r_stock[i] != '0))
                    r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end
        end
    end

    assign o_rd_price = (int'(i_rd_id) < N_PRODUCTS) ? r_price[i_rd_id] : '0;
    assign o_rd_stock = (int'(i_rd_id) < N_PRODUCTS) ? r_stock[i_rd_id] : '0;

endmodule

// File: rtl/vend_controller.sv
// Select/pay/dispense vending FSM with credit accumulation, cancel/refund and change.
// Define VEND_TIMEOUT_EN to refund automatically after TIMEOUT_CYCLES idle PAY cycles.
module vend_controller
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS     = DEF_N_PRODUCTS,
    parameter int PRICE_W        = DEF_PRICE_W,
    parameter int STOCK_W        = DEF_STOCK_W,
    parameter int INIT_STOCK     = DEF_INIT_STOCK,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W          = $clog2(N_PRODUCTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               price_wr_en,
    input  logic [ID_W-1:0]    price_wr_id,
    input  logic [PRICE_W-1:0] price_wr_data,
    input  logic               restock_en,
    input  logic [ID_W-1:0]    restock_id,
    input  logic               sel_valid,
    input  logic [ID_W-1:0]    sel_id,
    input  logic               coin_valid,
    input  logic [PRICE_W-1:0] coin_value,
    input  logic               cancel,
    output logic [STATE_W-1:0] state,
    output logic [PRICE_W-1:0] credit,
    output logic [PRICE_W-1:0] sel_price,
    output logic               dispense_valid,
    output logic [ID_W-1:0]    dispense_id,
    output logic               change_valid,
    output logic [PRICE_W-1:0] change,
    output logic               coin_reject,
    output logic               sold_out
);

    localparam logic [STATE_W-1:0] S_IDLE     = ST_IDLE;
    localparam logic [STATE_W-1:0] S_PAY      = ST_PAY;
    localparam logic [STATE_W-1:0] S_DISPENSE = ST_DISPENSE;
    localparam logic [STATE_W-1:0] S_REFUND   = ST_REFUND;

    logic [STATE_W-1:0] r_state;
    logic [PRICE_W-1:0] r_credit;
    logic [ID_W-1:0]    r_sel_id;
    logic [PRICE_W-1:0] r_sel_price;
    logic               r_dispense_valid;
    logic [ID_W-1:0]    r_dispense_id;
    logic               r_change_valid;
    logic [PRICE_W-1:0] r_change;
    logic               r_coin_reject;
    logic               r_sold_out;

    logic [PRICE_W-1:0] w_rd_price;
    logic [STOCK_W-1:0] w_rd_stock;
    logic [PRICE_W:0]   w_sum;
    logic               w_carry;
    logic               w_timeout;
    logic               w_abort;
    logic               w_sel_accept;
    logic               w_coin_accept;

    vend_slot_table #(
        .N_PRODUCTS (N_PRODUCTS),
        .PRICE_W    (PRICE_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_slots (
        .clk             (clk),
        .reset           (reset),
        .i_price_wr_en   (price_wr_en),
        .i_price_wr_id   (price_wr_id),
        .i_price_wr_data (price_wr_data),
        .i_restock_en    (restock_en),
        .i_restock_id    (restock_id),
        .i_dec_en        (r_state == S_DISPENSE),
        .i_dec_id        (r_sel_id),
        .i_rd_id         (sel_id),
        .o_rd_price      (w_rd_price),
        .o_rd_stock      (w_rd_stock)
    );

    assign w_sum         = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_carry       = w_sum[PRICE_W];
    assign w_abort       = cancel || w_timeout;
    assign w_sel_accept  = (r_state == S_IDLE) && sel_valid && (w_rd_stock != '0);
    assign w_coin_accept = (r_state == S_PAY) && coin_valid && !w_abort && !w_carry;

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;

    // Saturates at the limit so the refund decision stays stable until the FSM leaves PAY.
    always_ff @(posedge clk) begin
        if (reset || w_sel_accept || w_coin_accept)
            r_timer <= '0;
        else if ((r_state == S_PAY) && (r_timer != TMR_W'(TIMEOUT_CYCLES)))
            r_timer <= r_timer + TMR_W'(1);
    end

    assign w_timeout = (r_state == S_PAY) && (r_timer == TMR_W'(TIMEOUT_CYCLES));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Pulse outputs are registered, so they appear the cycle after the deciding edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_credit         <= '0;
            r_sel_id         <= '0;
            r_sel_price      <= '0;
            r_dispense_valid <= 1'b0;
            r_dispense_id    <= '0;
            r_change_valid   <= 1'b0;
            r_change         <= '0;
            r_coin_reject    <= 1'b0;
            r_sold_out       <= 1'b0;
        end else begin
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;
            r_change         <= '0;
            r_coin_reject    <= 1'b0;
            r_sold_out       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_accept) begin
                        r_sel_id    <= sel_id;
                        r_sel_price <= w_rd_price;
                        r_state     <= S_PAY;
                    end else if (sel_valid) begin
                        r_sold_out <= 1'b1;
                    end
                    if (coin_valid)
                        r_coin_reject <= 1'b1;
                end
                S_PAY: begin
                    if (w_abort) begin
                        r_coin_reject <= coin_valid;
                        r_state       <= S_REFUND;
                    end else begin
                        if (w_coin_accept)
                            r_credit <= w_sum[PRICE_W-1:0];
                        else if (coin_valid)
                            r_coin_reject <= 1'b1;
                        if (r_credit >= r_sel_price)
                            r_state <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    r_dispense_valid <= 1'b1;
                    r_dispense_id    <= r_sel_id;
                    r_change_valid   <= 1'b1;
                    r_change         <= r_credit - r_sel_price;
                    r_credit         <= '0;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_change_valid <= 1'b1;
                    r_change       <= r_credit;
                    r_credit       <= '0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign state          = r_state;
    assign credit         = r_credit;
    assign sel_price      = r_sel_price;
    assign dispense_valid = r_dispense_valid;
    assign dispense_id    = r_dispense_id;
    assign change_valid   = r_change_valid;
    assign change         = r_change;
    assign coin_reject    = r_coin_reject;
    assign sold_out       = r_sold_out;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: directed purchases push expected pulses,
// a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_vend_controller;

    localparam int ID_W = 3;
    localparam int PW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            price_wr_en;
    logic [ID_W-1:0] price_wr_id;
    logic [PW-1:0]   price_wr_data;
    logic            restock_en;
    logic [ID_W-1:0] restock_id;
    logic            sel_valid;
    logic [ID_W-1:0] sel_id;
    logic            coin_valid;
    logic [PW-1:0]   coin_value;
    logic            cancel;
    logic [1:0]      state;
    logic [PW-1:0]   credit;
    logic [PW-1:0]   sel_price;
    logic            dispense_valid;
    logic [ID_W-1:0] dispense_id;
    logic            change_valid;
    logic [PW-1:0]   change;
    logic            coin_reject;
    logic            sold_out;

    always #5 clk = ~clk;

    vend_controller #(
        .N_PRODUCTS     (8),
        .PRICE_W        (PW),
        .STOCK_W        (4),
        .INIT_STOCK     (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .price_wr_en    (price_wr_en),
        .price_wr_id    (price_wr_id),
        .price_wr_data  (price_wr_data),
        .restock_en     (restock_en),
        .restock_id     (restock_id),
        .sel_valid      (sel_valid),
        .sel_id         (sel_id),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .cancel         (cancel),
        .state          (state),
        .credit         (credit),
        .sel_price      (sel_price),
        .dispense_valid (dispense_valid),
        .dispense_id    (dispense_id),
        .change_valid   (change_valid),
        .change         (change),
        .coin_reject    (coin_reject),
        .sold_out       (sold_out)
    );

    typedef enum int {EV_DISP = 0, EV_REFUND = 1, EV_SOLDOUT = 2, EV_REJECT = 3} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       id;
        int       value;
    } ev_t;

    ev_t expQ[$];
    int  errors = 0;
    int  checks = 0;

    function automatic void pushExp(input ev_kind_e k, input int id, input int v);
        ev_t e;
        e.kind  = k;
        e.id    = id;
        e.value = v;
        expQ.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic popCheck(input ev_kind_e k, input int id, input int val, input logic cv);
        ev_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = expQ.pop_front();
        checkOutput("event_kind", k, e.kind);
        if (k == EV_DISP) begin
            checkOutput("dispense_id", id, e.id);
            checkOutput("dispense_change", val, e.value);
            checkOutput("dispense_change_valid", cv, 1);
        end else if (k == EV_REFUND) begin
            checkOutput("refund_change", val, e.value);
        end
    endtask

    // Monitor: every pulse the DUT emits must match the next expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (dispense_valid)
                popCheck(EV_DISP, int'(dispense_id), int'(change), change_valid);
            else if (change_valid)
                popCheck(EV_REFUND, 0, int'(change), 1'b1);
            if (sold_out)
                popCheck(EV_SOLDOUT, 0, 0, 1'b1);
            if (coin_reject)
                popCheck(EV_REJECT, 0, 0, 1'b1);
        end
    end

    task automatic applyStimulus(input logic sv, input logic [ID_W-1:0] sid,
                                 input logic cv, input logic [PW-1:0] cval, input logic can);
        sel_valid  = sv;
        sel_id     = sid;
        coin_valid = cv;
        coin_value = cval;
        cancel     = can;
        @(posedge clk);
        #1;
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic writePrice(input logic [ID_W-1:0] id, input logic [PW-1:0] data);
        price_wr_en   = 1'b1;
        price_wr_id   = id;
        price_wr_data = data;
        @(posedge clk);
        #1;
        price_wr_en = 1'b0;
    endtask

    task automatic restockSlot(input logic [ID_W-1:0] id);
        restock_en = 1'b1;
        restock_id = id;
        @(posedge clk);
        #1;
        restock_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        int n;
        n = 0;
        while (state !== 2'd0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, state, 0);
    endtask

    initial begin
        reset = 1'b1;
        price_wr_en = 1'b0; price_wr_id = '0; price_wr_data = '0;
        restock_en = 1'b0; restock_id = '0;
        sel_valid = 1'b0; sel_id = '0;
        coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
        idleCycles(3);
        checkOutput("reset_state", state, 0);
        checkOutput("reset_credit", credit, 0);
        checkOutput("reset_sel_price", sel_price, 0);
        checkOutput("reset_pulses", {dispense_valid, change_valid, coin_reject, sold_out}, 0);
        reset = 1'b0;
        idleCycles(1);

        for (int k = 0; k < 8; k++)
            writePrice(ID_W'(k), PW'(10 * (k + 1)));

        // Purchase id 1 (price 20) with 10+15, change 5.
        applyStimulus(1'b1, 3'd1, 1'b0, 8'd0, 1'b0);
        checkOutput("sel1_state", state, 1);
        checkOutput("sel1_price", sel_price, 20);
        pushExp(EV_DISP, 1, 5);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd10, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd15, 1'b0);
        checkOutput("sel1_credit", credit, 25);
        waitIdle("sel1_back_idle", 20);
        checkOutput("sel1_credit_clear", credit, 0);

        // Drain slot 2 at exact price, then sold out, then restock.
        for (int n = 0; n < 4; n++) begin
            pushExp(EV_DISP, 2, 0);
            applyStimulus(1'b1, 3'd2, 1'b0, 8'd0, 1'b0);
            applyStimulus(1'b0, 3'd0, 1'b1, 8'd30, 1'b0);
            waitIdle("slot2_buy_idle", 20);
        end
        pushExp(EV_SOLDOUT, 0, 0);
        applyStimulus(1'b1, 3'd2, 1'b0, 8'd0, 1'b0);
        checkOutput("soldout_state", state, 0);
        idleCycles(1);
        restockSlot(3'd2);
        applyStimulus(1'b1, 3'd2, 1'b0, 8'd0, 1'b0);
        checkOutput("restock_sel_state", state, 1);
        pushExp(EV_DISP, 2, 0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd30, 1'b0);
        waitIdle("restock_buy_idle", 20);

        // Cancel refunds credit; coin with cancel is rejected.
        applyStimulus(1'b1, 3'd7, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd50, 1'b0);
        checkOutput("cancel_credit", credit, 50);
        pushExp(EV_REFUND, 0, 50);
        applyStimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b1);
        checkOutput("cancel_state_refund", state, 3);
        waitIdle("cancel_idle", 20);
        applyStimulus(1'b1, 3'd7, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd20, 1'b0);
        pushExp(EV_REJECT, 0, 0);
        pushExp(EV_REFUND, 0, 20);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd10, 1'b1);
        waitIdle("cancel_coin_idle", 20);

        // Credit overflow: 200 + 100 does not fit 8 bits.
        writePrice(3'd0, 8'd250);
        applyStimulus(1'b1, 3'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd100, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd100, 1'b0);
        pushExp(EV_REJECT, 0, 0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd100, 1'b0);
        checkOutput("overflow_credit", credit, 200);
        checkOutput("overflow_state", state, 1);
        pushExp(EV_REFUND, 0, 200);
        applyStimulus(1'b0, 3'd0, 1'b0, 8'd0, 1'b1);
        waitIdle("overflow_idle", 20);

        // Coin while idle.
        pushExp(EV_REJECT, 0, 0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd25, 1'b0);
        checkOutput("idle_coin_credit", credit, 0);
        checkOutput("idle_coin_state", state, 0);

        // Price rewrite does not disturb the latched price.
        applyStimulus(1'b1, 3'd3, 1'b0, 8'd0, 1'b0);
        checkOutput("latched_price", sel_price, 40);
        writePrice(3'd3, 8'd99);
        checkOutput("latched_price_after_wr", sel_price, 40);
        pushExp(EV_DISP, 3, 0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd40, 1'b0);
        waitIdle("rewrite_idle", 20);

        // Zero price dispenses on the first PAY cycle.
        writePrice(3'd5, 8'd0);
        pushExp(EV_DISP, 5, 0);
        applyStimulus(1'b1, 3'd5, 1'b0, 8'd0, 1'b0);
        waitIdle("zero_price_idle", 5);

`ifdef VEND_TIMEOUT_EN
        applyStimulus(1'b1, 3'd1, 1'b0, 8'd0, 1'b0);
        pushExp(EV_REFUND, 0, 5);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd5, 1'b0);
        waitIdle("timeout_idle", 40);
`endif

        // Reset during PAY discards credit without any refund pulse.
        idleCycles(2);
        applyStimulus(1'b1, 3'd4, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd10, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 8'd20, 1'b0);
        checkOutput("prereset_credit", credit, 30);
        checkOutput("prereset_state", state, 1);
        reset = 1'b1;
        idleCycles(1);
        checkOutput("midreset_state", state, 0);
        checkOutput("midreset_credit", credit, 0);
        reset = 1'b0;
        idleCycles(4);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
